// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared Y86-64 icode/stat constants and control FSM encoding
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  function automatic logic is_exc(input logic [2:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_detect.sv
// ============================================================================
// pipe_hazard_detect : combinational load/use, ret-in-flight and mispredict terms
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] D_icode_i,
  input  logic [3:0] d_srcA_i,
  input  logic [3:0] d_srcB_i,
  input  logic [3:0] E_icode_i,
  input  logic [3:0] E_dstM_i,
  input  logic       e_Cnd_i,
  input  logic [3:0] M_icode_i,
  output logic       lu_o,
  output logic       ret_o,
  output logic       mp_o
);

  assign lu_o  = ((E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ)) &&
                 (E_dstM_i != RNONE) &&
                 ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));

  assign ret_o = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);

  assign mp_o  = (E_icode_i == I_JXX) && !e_Cnd_i;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : Y86-64 pipeline stall/bubble control with run/halt FSM.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [2:0]       final_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic   lu, ret, mp;
  state_t state_q;
  logic   halted_q;
  logic [2:0] final_stat_q;

  pipe_hazard_detect u_hazard (
    .D_icode_i (D_icode),
    .d_srcA_i  (d_srcA),
    .d_srcB_i  (d_srcB),
    .E_icode_i (E_icode),
    .E_dstM_i  (E_dstM),
    .e_Cnd_i   (e_Cnd),
    .M_icode_i (M_icode),
    .lu_o      (lu),
    .ret_o     (ret),
    .mp_o      (mp)
  );

  // Reset flushes the pipe regardless of FSM state; HALTED freezes everything.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    if (rst) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state_q == ST_HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end else begin
      F_stall  = lu | ret;
      D_stall  = lu;
      D_bubble = mp | (!lu & ret);
      E_bubble = mp | lu;
      M_bubble = is_exc(m_stat) | is_exc(W_stat);
      W_stall  = is_exc(W_stat);
      set_cc   = (E_icode == I_OPQ) & !is_exc(m_stat) & !is_exc(W_stat);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      halted_q     <= 1'b0;
      final_stat_q <= S_AOK;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (is_exc(W_stat)) begin
            state_q      <= ST_HALTED;
            halted_q     <= 1'b1;
            final_stat_q <= W_stat;
          end
        end
        default: begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign halted     = halted_q;
  assign final_stat = final_stat_q;

`ifdef PIPE_CTRL_PERF_EN
  logic             run;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign run = (state_q == ST_RUN);

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    stall_d   = stall_q;
    if (run) begin
      if (cycle_q != '1)
        cycle_d = cycle_q + CNT_W'(1);
      if ((W_stat == S_AOK) && (instret_q != '1))
        instret_d = instret_q + CNT_W'(1);
      if ((F_stall | D_bubble | E_bubble) && (stall_q != '1))
        stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      stall_q   <= stall_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign stall_cnt   = stall_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : self-checking bench for pipe_ctrl (vector table, directed
// halt/reset sequences, randomized run against a behavioural model).
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  localparam int W = 4;
  localparam int SAT = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic e_Cnd;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [2:0] final_stat;
  logic [W-1:0] cycle_cnt, instret_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_halted;
  int m_fstat, m_cyc, m_inst, m_stall;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .halted(halted), .final_stat(final_stat),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [3:0] D_icode;
    logic [3:0] srcA;
    logic [3:0] srcB;
    logic [3:0] E_icode;
    logic [3:0] E_dstM;
    logic       e_Cnd;
    logic [3:0] M_icode;
    logic [2:0] m_stat;
    logic [2:0] W_stat;
    logic [6:0] exp;   // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
  } vec_t;

  vec_t tbl[12];

  function automatic bit exc(input int s);
    return (s == 2) || (s == 3) || (s == 4);
  endfunction

  function automatic logic [6:0] dut_outs();
    return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
  endfunction

  // Expected control word derived directly from the hazard rules.
  function automatic logic [6:0] model_outs();
    bit lu, rt, mp;
    lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
         (E_dstM == d_srcA || E_dstM == d_srcB);
    rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    mp = (E_icode == 4'h7) && !e_Cnd;
    if (rst) return 7'b0011100;
    if (m_halted) return 7'b1100110;
    return {lu | rt, lu, mp | (!lu && rt), mp | lu,
            exc(m_stat) | exc(W_stat), exc(W_stat),
            (E_icode == 4'h6) && !exc(m_stat) && !exc(W_stat)};
  endfunction

  function automatic int exp_cnt(input int v);
`ifdef PIPE_CTRL_PERF_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("ctrl", {25'd0, dut_outs()}, {25'd0, model_outs()});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("final_stat", {29'd0, final_stat}, m_fstat);
    chk("cycle_cnt", {28'd0, cycle_cnt}, exp_cnt(m_cyc));
    chk("instret_cnt", {28'd0, instret_cnt}, exp_cnt(m_inst));
    chk("stall_cnt", {28'd0, stall_cnt}, exp_cnt(m_stall));
  endtask

  task automatic model_update();
    logic [6:0] o;
    o = model_outs();
    if (rst) begin
      m_halted = 0; m_fstat = 1; m_cyc = 0; m_inst = 0; m_stall = 0;
    end else if (!m_halted) begin
      if (m_cyc < SAT) m_cyc++;
      if (W_stat == 3'd1 && m_inst < SAT) m_inst++;
      if ((o[6] | o[4] | o[3]) && m_stall < SAT) m_stall++;
      if (exc(W_stat)) begin
        m_halted = 1;
        m_fstat = W_stat;
      end
    end
  endtask

  // Inputs already driven; check at negedge, then advance one clock.
  task automatic cycle(input bit use_exp, input logic [6:0] exp);
    @(negedge clk);
    model_check();
    if (use_exp) chk("vector", {25'd0, dut_outs()}, {25'd0, exp});
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [3:0] di, sa, sb, ei, ed, input logic c,
                       input logic [3:0] mi, input logic [2:0] ms, ws);
    D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = ed;
    e_Cnd = c; M_icode = mi; m_stat = ms; W_stat = ws;
  endtask

  task automatic drive_idle();
    drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1);
  endtask

  task automatic drive_random(input bit allow_exc);
    logic [3:0] pick[8];
    pick = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h2, 4'h0};
    D_icode = pick[$urandom_range(0, 7)];
    E_icode = pick[$urandom_range(0, 7)];
    M_icode = pick[$urandom_range(0, 7)];
    d_srcA  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    d_srcB  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    E_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    e_Cnd   = 1'($urandom_range(0, 1));
    m_stat  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1));
    W_stat  = (allow_exc && $urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4))
                                                       : 3'($urandom_range(0, 1));
  endtask

  initial begin
    tbl[0]  = '{4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 7'b1101000};
    tbl[1]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 7'b0011000};
    tbl[2]  = '{4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 7'b1010000};
    tbl[3]  = '{4'h1, 4'h4, 4'hF, 4'h9, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 7'b1010000};
    tbl[4]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h9, 3'd1, 3'd1, 7'b1010000};
    tbl[5]  = '{4'h1, 4'hF, 4'h3, 4'h5, 4'h3, 1'b1, 4'h9, 3'd1, 3'd1, 7'b1101000};
    tbl[6]  = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 7'b0000001};
    tbl[7]  = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1, 7'b0000100};
    tbl[8]  = '{4'h1, 4'hF, 4'hF, 4'hB, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 7'b0000000};
    tbl[9]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 3'd0, 7'b0000000};
    tbl[10] = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd2, 3'd1, 7'b0000100};
    tbl[11] = '{4'h1, 4'h5, 4'h2, 4'hB, 4'h2, 1'b0, 4'h1, 3'd1, 3'd1, 7'b1101000};

    m_halted = 0; m_fstat = 1; m_cyc = 0; m_inst = 0; m_stall = 0;
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    model_update();
    #1;
    cycle(1'b1, 7'b0011100);   // reset state while rst held
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].D_icode, tbl[i].srcA, tbl[i].srcB, tbl[i].E_icode, tbl[i].E_dstM,
            tbl[i].e_Cnd, tbl[i].M_icode, tbl[i].m_stat, tbl[i].W_stat);
      cycle(1'b1, tbl[i].exp);
    end

    // Exception walks from M into W, then the pipe freezes.
    drive(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1);
    cycle(1'b1, 7'b0000100);
    drive(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd3);
    cycle(1'b1, 7'b0000110);
    for (int i = 0; i < 10; i++) begin
      drive_random(1'b1);
      @(negedge clk);
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_final", {29'd0, final_stat}, 32'd3);
      #0;
      @(posedge clk);
      model_update();
      #1;
      cycle(1'b1, 7'b1100110);
    end

    // Reset out of HALTED.
    rst = 1'b1;
    drive_random(1'b1);
    cycle(1'b1, 7'b0011100);
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_final", {29'd0, final_stat}, 32'd1);
    chk("rst_cycle", {28'd0, cycle_cnt}, 32'd0);

    // Saturation: 20 idle RUN cycles with SAOK retiring.
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < 19; i++) cycle(1'b0, 7'd0);
    @(negedge clk);
    chk("sat_cycle", {28'd0, cycle_cnt}, exp_cnt(SAT));
    chk("sat_instret", {28'd0, instret_cnt}, exp_cnt(SAT));
    @(posedge clk);
    model_update();
    #1;

    // Randomized run with occasional halts and resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive_random(1'b1);
      cycle(1'b0, 7'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
